// File: rtl/cosmos_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cosmos_gen_pkg
// Purpose : Shared types and constants for the constraint generator and the
//           constraint checkers. Provides the filter-mode and generator-state
//           encodings, the default equality target, and a filter helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cosmos_gen_pkg;

    // Filter mode as seen on filt_mode. Encoding 2'b11 is not named and
    // behaves like FILT_ALL.
    typedef enum logic [1:0] {
        FILT_ALL   = 2'b00,
        FILT_SAT   = 2'b01,
        FILT_UNSAT = 2'b10
    } filt_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        FIN   = 2'b11
    } gen_state_e;

    localparam logic [31:0] C_DEFAULT_TARGET = 32'h000411a2;

    // Decide whether an evaluated candidate is forwarded to the output.
    function automatic logic filt_pass(input logic [1:0] mode, input logic sat);
        logic pass;
        pass = 1'b1;
        if (mode == FILT_SAT) begin
            pass = sat;
        end else if (mode == FILT_UNSAT) begin
            pass = !sat;
        end
        return pass;
    endfunction

endpackage
`default_nettype wire

// File: rtl/constraint_eq_eval.sv
`default_nettype none
// ============================================================================
// Module  : constraint_eq_eval
// Purpose : Combinational evaluator for the equality constraint cand == TARGET.
//           The comparison is done in 32-bit modulo arithmetic on the
//           zero-extended candidate, so a TARGET that does not fit in W bits
//           is never satisfied.
// Ports   : cand  in  W  candidate value
//           sat   out 1  candidate satisfies the constraint
// Revision: 1.0 - initial release
// ============================================================================
module constraint_eq_eval
    import cosmos_gen_pkg::*;
#(
    parameter int          W      = 20,
    parameter logic [31:0] TARGET = C_DEFAULT_TARGET
) (
    input  logic [W-1:0] cand,
    output logic         sat
);

    logic [31:0] w_diff;

    assign w_diff = 32'(cand) - TARGET;
    assign sat    = (w_diff == 32'h0);

endmodule
`default_nettype wire

// File: rtl/constraint_sat_gen.sv
`default_nettype none
// ============================================================================
// Module  : constraint_sat_gen
// Purpose : Sweeps the inclusive range [lo, hi], evaluates the equality
//           constraint on every candidate and streams the filtered candidates
//           over a valid/ready channel. Reports SAT/emit counts and a done
//           pulse at the end of each sweep.
// Ports   : clk, rst_n            clock / async active-low reset
//           start, lo, hi,        sweep launch and range/filter, captured
//           filt_mode             in IDLE
//           cand_valid/ready      output handshake
//           cand_data, cand_sat   beat payload
//           busy, done            status (done is a one-cycle pulse)
//           sat_count, emit_count sweep statistics (saturating)
// Revision: 1.0 - initial release
// ============================================================================
module constraint_sat_gen
    import cosmos_gen_pkg::*;
#(
    parameter int          W      = 20,
    parameter logic [31:0] TARGET = C_DEFAULT_TARGET,
    parameter int          CW     = 21
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [1:0]    filt_mode,
    output logic          cand_valid,
    input  logic          cand_ready,
    output logic [W-1:0]  cand_data,
    output logic          cand_sat,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] sat_count,
    output logic [CW-1:0] emit_count
);

    localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

    gen_state_e    r_state;
    logic [W-1:0]  r_cur;
    logic [W-1:0]  r_hi;
    logic [1:0]    r_filt;
    logic          r_valid;
    logic [W-1:0]  r_data;
    logic          r_sat;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_sat_cnt;
    logic [CW-1:0] r_emit_cnt;

    logic w_sat;
    logic w_pass;
    logic w_xfer;
    logic w_slot_free;

    constraint_eq_eval #(
        .W      (W),
        .TARGET (TARGET)
    ) u_eval (
        .cand (r_cur),
        .sat  (w_sat)
    );

    assign w_pass      = filt_pass(r_filt, w_sat);
    assign w_xfer      = r_valid && cand_ready;
    // The output register can take a new candidate when empty or draining now.
    assign w_slot_free = !r_valid || cand_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cur      <= '0;
            r_hi       <= '0;
            r_filt     <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_sat      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sat_cnt  <= '0;
            r_emit_cnt <= '0;
        end else begin
            if (w_xfer && (r_emit_cnt != C_CNT_MAX)) begin
                r_emit_cnt <= r_emit_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_hi       <= hi;
                        r_filt     <= filt_mode;
                        r_cur      <= lo;
                        r_sat_cnt  <= '0;
                        r_emit_cnt <= '0;
                        if (lo > hi) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (w_slot_free) begin
                        if (w_sat && (r_sat_cnt != C_CNT_MAX)) begin
                            r_sat_cnt <= r_sat_cnt + 1'b1;
                        end
                        // A filtered-out candidate leaves the slot empty.
                        r_valid <= w_pass;
                        if (w_pass) begin
                            r_data <= r_cur;
                            r_sat  <= w_sat;
                        end
                        // Stop at hi rather than incrementing, so hi = all-ones
                        // never wraps back to zero.
                        if (r_cur == r_hi) begin
                            r_state <= DRAIN;
                        end else begin
                            r_cur <= r_cur + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (w_slot_free) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end

                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cand_valid = r_valid;
    assign cand_data  = r_data;
    assign cand_sat   = r_sat;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sat_count  = r_sat_cnt;
    assign emit_count = r_emit_cnt;

endmodule
`default_nettype wire
